// File: rtl/instr_fetch.sv
// instr_fetch: PC register and req/ack fetch from instruction memory into a valid/ready instruction register
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc4,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);
  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;
  state_t      r_state, w_next;
  logic [31:0] r_fetch_pc, r_instr, r_instr_pc, r_instr_pc4;
  logic [31:0] w_pc_next;
  logic        w_take;
  always_comb begin
    w_next = r_state;
    w_take = (r_state == REQ) && imem_ack && !redirect;
    w_pc_next = r_fetch_pc + 32'd4;
    if (redirect) w_next = REQ;
    else w_next = (r_state == IDLE) ? REQ :
                  (r_state == REQ)  ? (imem_ack ? HOLD : REQ) :
                  (instr_ready ? REQ : HOLD);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_fetch_pc  <= RESET_PC;
      r_instr     <= '0;
      r_instr_pc  <= '0;
      r_instr_pc4 <= '0;
    end else begin
      r_state    <= w_next;
      r_fetch_pc <= redirect ? {redirect_pc[31:2], 2'b00} : w_take ? w_pc_next : r_fetch_pc;
      if (w_take) begin
        r_instr     <= imem_rdata;
        r_instr_pc  <= r_fetch_pc;
        r_instr_pc4 <= w_pc_next;
      end
    end
  end
  assign imem_req    = r_state == REQ;
  assign imem_addr   = {r_fetch_pc[31:2], 2'b00};
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_pc4   = r_instr_pc4;
  assign instr_valid = r_state == HOLD;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: table-driven check of instr_fetch with a zero-wait xor memory model
module tb_instr_fetch;
  logic        clk = 0, rst = 1;
  logic        ack = 0, ready = 0, redir = 0;
  logic [31:0] redir_pc = '0;
  logic        req, valid, req2, valid2;
  logic [31:0] addr, rdata, ins, ipc, ipc4;
  logic [31:0] addr2, rdata2, ins2, ipc2, ipc42;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  assign rdata  = addr ^ 32'hA5A5_0000;
  assign rdata2 = addr2 ^ 32'hA5A5_0000;
  instr_fetch u_dut (
    .clk(clk), .rst(rst), .imem_req(req), .imem_addr(addr), .imem_ack(ack), .imem_rdata(rdata),
    .instr(ins), .instr_pc(ipc), .instr_pc4(ipc4), .instr_valid(valid), .instr_ready(ready),
    .redirect(redir), .redirect_pc(redir_pc)
  );
  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_dut_hi (
    .clk(clk), .rst(rst), .imem_req(req2), .imem_addr(addr2), .imem_ack(ack), .imem_rdata(rdata2),
    .instr(ins2), .instr_pc(ipc2), .instr_pc4(ipc42), .instr_valid(valid2), .instr_ready(ready),
    .redirect(redir), .redirect_pc(redir_pc)
  );
  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic        ack;
    logic        ready;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] pc4;
  } vec_t;
  vec_t v[20];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic chk_all(input string tag, input logic r, input logic [31:0] a, input logic vl,
                         input logic [31:0] in, input logic [31:0] p, input logic [31:0] p4);
    chk({tag, ".req"}, {31'd0, req}, {31'd0, r});
    chk({tag, ".addr"}, addr, a);
    chk({tag, ".valid"}, {31'd0, valid}, {31'd0, vl});
    chk({tag, ".instr"}, ins, in);
    chk({tag, ".instr_pc"}, ipc, p);
    chk({tag, ".instr_pc4"}, ipc4, p4);
  endtask
  initial begin
    v[0]  = '{0, 0,      0, 0, 0, 32'h000, 0, 32'h0,         32'h000, 32'h000};
    v[1]  = '{0, 0,      1, 0, 1, 32'h000, 0, 32'h0,         32'h000, 32'h000};
    v[2]  = '{0, 0,      1, 1, 0, 32'h004, 1, 32'hA5A5_0000, 32'h000, 32'h004};
    v[3]  = '{0, 0,      0, 0, 1, 32'h004, 0, 32'hA5A5_0000, 32'h000, 32'h004};
    v[4]  = '{0, 0,      0, 0, 1, 32'h004, 0, 32'hA5A5_0000, 32'h000, 32'h004};
    v[5]  = '{0, 0,      0, 0, 1, 32'h004, 0, 32'hA5A5_0000, 32'h000, 32'h004};
    v[6]  = '{0, 0,      1, 0, 1, 32'h004, 0, 32'hA5A5_0000, 32'h000, 32'h004};
    v[7]  = '{0, 0,      1, 0, 0, 32'h008, 1, 32'hA5A5_0004, 32'h004, 32'h008};
    v[8]  = '{0, 0,      1, 0, 0, 32'h008, 1, 32'hA5A5_0004, 32'h004, 32'h008};
    v[9]  = '{0, 0,      1, 0, 0, 32'h008, 1, 32'hA5A5_0004, 32'h004, 32'h008};
    v[10] = '{0, 0,      1, 0, 0, 32'h008, 1, 32'hA5A5_0004, 32'h004, 32'h008};
    v[11] = '{0, 0,      1, 0, 0, 32'h008, 1, 32'hA5A5_0004, 32'h004, 32'h008};
    v[12] = '{0, 0,      0, 1, 0, 32'h008, 1, 32'hA5A5_0004, 32'h004, 32'h008};
    v[13] = '{1, 32'h103, 1, 0, 1, 32'h008, 0, 32'hA5A5_0004, 32'h004, 32'h008};
    v[14] = '{0, 0,      0, 0, 1, 32'h100, 0, 32'hA5A5_0004, 32'h004, 32'h008};
    v[15] = '{0, 0,      1, 0, 1, 32'h100, 0, 32'hA5A5_0004, 32'h004, 32'h008};
    v[16] = '{1, 32'h200, 0, 0, 0, 32'h104, 1, 32'hA5A5_0100, 32'h100, 32'h104};
    v[17] = '{0, 0,      0, 1, 1, 32'h200, 0, 32'hA5A5_0100, 32'h100, 32'h104};
    v[18] = '{0, 0,      1, 1, 1, 32'h200, 0, 32'hA5A5_0100, 32'h100, 32'h104};
    v[19] = '{0, 0,      0, 1, 0, 32'h204, 1, 32'hA5A5_0200, 32'h200, 32'h204};
    #12;
    chk_all("reset", 0, 32'h0, 0, 32'h0, 32'h0, 32'h0);
    chk("reset_hi.addr", addr2, 32'hFFFF_FFFC);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk);
      redir = v[i].redir; redir_pc = v[i].rpc; ack = v[i].ack; ready = v[i].ready;
      #1;
      chk_all($sformatf("vec%0d", i), v[i].req, v[i].addr, v[i].valid, v[i].ins, v[i].pc, v[i].pc4);
      if (i == 2) begin
        chk("wrap.instr_pc", ipc2, 32'hFFFF_FFFC);
        chk("wrap.instr_pc4", ipc42, 32'h0);
        chk("wrap.instr", ins2, 32'h5A5A_FFFC);
        chk("wrap.next_addr", addr2, 32'h0);
      end
    end
    @(negedge clk);
    redir = 0; ack = 0; ready = 0;
    #1;
    chk("t6.pre_req", {31'd0, req}, 32'd1);
    chk("t6.pre_addr", addr, 32'h204);
    #2;
    rst = 1; ack = 1;
    #1;
    chk_all("t6.async", 0, 32'h0, 0, 32'h0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    chk_all("t6.held", 0, 32'h0, 0, 32'h0, 32'h0, 32'h0);
    ack = 0; rst = 0;
    #1;
    chk_all("t6.idle", 0, 32'h0, 0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    ack = 1;
    #1;
    chk_all("t6.req", 1, 32'h0, 0, 32'h0, 32'h0, 32'h0);
    chk("t6.hi_addr", addr2, 32'hFFFF_FFFC);
    @(negedge clk);
    ack = 0;
    #1;
    chk_all("t6.first", 0, 32'h4, 1, 32'hA5A5_0000, 32'h0, 32'h4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
